// File: rtl/led_pattern_pkg.sv
// Shared mode encoding and start-pattern helper for the LED pattern generator.
package led_pattern_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_FILL  = 2'd0;
    localparam mode_t MODE_DOT   = 2'd1;
    localparam mode_t MODE_BLINK = 2'd2;
    localparam mode_t MODE_COUNT = 2'd3;

    // DOT starts with only the MSB lit; every other mode starts dark.
    function automatic logic [31:0] start_pattern(input mode_t mode, input int width);
        logic [31:0] pat;
        pat = '0;
        if (mode == MODE_DOT) begin
            pat = 32'd1 << (width - 1);
        end
        return pat;
    endfunction

endpackage

// File: rtl/led_pattern_step.sv
// Combinational next-frame logic: one animation step of the selected mode.
module led_pattern_step
    import led_pattern_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] led,
    output logic [WIDTH-1:0] next_led,
    output logic             next_dir
);

    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        next_led = led;
        next_dir = dir;
        case (mode)
            MODE_FILL: begin
                if (!dir) begin
                    if (&led) begin
                        next_dir = 1'b1;
                        next_led = led << 1;
                    end else begin
                        next_led = (led >> 1) | MSB;
                    end
                end else begin
                    if (led == '0) begin
                        next_dir = 1'b0;
                        next_led = MSB;
                    end else begin
                        next_led = led << 1;
                    end
                end
            end
            MODE_DOT: begin
                // A dark display cannot bounce; restart the dot from the MSB.
                if (led == '0) begin
                    next_dir = 1'b0;
                    next_led = MSB;
                end else if (!dir) begin
                    if (led[0]) begin
                        next_dir = 1'b1;
                        next_led = led << 1;
                    end else begin
                        next_led = led >> 1;
                    end
                end else begin
                    if (led[WIDTH-1]) begin
                        next_dir = 1'b0;
                        next_led = led >> 1;
                    end else begin
                        next_led = led << 1;
                    end
                end
            end
            MODE_BLINK: begin
                next_led = ~led;
            end
            MODE_COUNT: begin
                next_led = led + WIDTH'(1);
                next_dir = 1'b0;
            end
            default: begin
                next_led = led;
                next_dir = dir;
            end
        endcase
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Frame generator between the frame counter and the LED output register:
// holds mode/frame/direction state and flags the end of each animation period.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int RST_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fc,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             period_done
);

    localparam mode_t            RST_MODE_M = mode_t'(RST_MODE);
    localparam logic [WIDTH-1:0] RST_LED    = WIDTH'(start_pattern(RST_MODE_M, WIDTH));

    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             dir_q, dir_d;
    logic             pd_q, pd_d;

    logic [WIDTH-1:0] step_led;
    logic             step_dir;
    logic [WIDTH-1:0] start_new;
    logic [WIDTH-1:0] start_cur;

    led_pattern_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode    (mode_q),
        .dir     (dir_q),
        .led     (led_q),
        .next_led(step_led),
        .next_dir(step_dir)
    );

    assign start_new = WIDTH'(start_pattern(mode, WIDTH));
    assign start_cur = WIDTH'(start_pattern(mode_q, WIDTH));

    // A mode change outranks a step, so fc in the same cycle is dropped.
    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        dir_d  = dir_q;
        pd_d   = 1'b0;
        if (mode != mode_q) begin
            mode_d = mode;
            led_d  = start_new;
            dir_d  = 1'b0;
        end else if (en && fc) begin
            led_d = step_led;
            dir_d = step_dir;
            pd_d  = (step_led == start_cur);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= RST_MODE_M;
            led_q  <= RST_LED;
            dir_q  <= 1'b0;
            pd_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            pd_q   <= pd_d;
        end
    end

    assign led         = led_q;
    assign period_done = pd_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a 16-LED instance and a 4-LED instance
// sharing clock, reset and control inputs.
module tb_led_pattern_gen;

    logic        clk;
    logic        rst;
    logic        fc;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] led16;
    logic        pd16;
    logic [3:0]  led4;
    logic        pd4;

    int checks   = 0;
    int failures = 0;

    led_pattern_gen #(.WIDTH(16), .RST_MODE(0)) dut16 (
        .clk(clk), .rst(rst), .fc(fc), .en(en), .mode(mode),
        .led(led16), .period_done(pd16)
    );

    led_pattern_gen #(.WIDTH(4), .RST_MODE(1)) dut4 (
        .clk(clk), .rst(rst), .fc(fc), .en(en), .mode(mode),
        .led(led4), .period_done(pd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between clock edges.
    task automatic areset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Top n bits of a 16-bit word set.
    function automatic logic [15:0] top16(input int n);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[15-i] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] fill16(input int k);
        int n;
        if (k <= 16)      n = k;
        else if (k <= 32) n = 32 - k;
        else              n = k - 32;
        return top16(n);
    endfunction

    function automatic logic [15:0] dot16(input int k);
        if (k <= 15) return 16'h8000 >> k;
        return 16'h0001 << (k - 15);
    endfunction

    logic [3:0] seq4 [8];
    int bad;
    int npd;
    int badpd;

    initial begin
        seq4 = '{4'h8, 4'hC, 4'hE, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        rst  = 1'b1;
        fc   = 1'b0;
        en   = 1'b1;
        mode = 2'd0;
        #12;
        chk("rst_led16", led16, 16'h0000);
        chk("rst_pd16", pd16, 1'b0);
        chk("rst_led4_dot", led4, 4'h8);
        chk("rst_pd4", pd4, 1'b0);
        fc = 1'b1;
        tick();
        chk("fc_during_rst", led16, 16'h0000);
        fc  = 1'b0;
        rst = 1'b0;
        tick();

        // FILL sweep, 40 steps
        for (int k = 1; k <= 40; k++) begin
            fc = 1'b1;
            tick();
            chk($sformatf("fill_led_%0d", k), led16, fill16(k));
            chk($sformatf("fill_pd_%0d", k), pd16, (k == 32) ? 1'b1 : 1'b0);
        end
        fc = 1'b0;

        // Asynchronous reset at FFF0 heading toward empty
        areset();
        for (int k = 1; k <= 20; k++) begin
            fc = 1'b1;
            tick();
        end
        fc = 1'b0;
        chk("fill_at_fff0", led16, 16'hFFF0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_led", led16, 16'h0000);
        rst = 1'b0;
        fc  = 1'b1;
        tick();
        fc = 1'b0;
        chk("after_rst_dir0", led16, 16'h8000);

        // en=0 freezes the frame
        areset();
        for (int k = 1; k <= 3; k++) begin
            fc = 1'b1;
            tick();
        end
        chk("fill_e000", led16, 16'hE000);
        en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            fc = 1'b1;
            tick();
            chk($sformatf("frz_led_%0d", k), led16, 16'hE000);
            chk($sformatf("frz_pd_%0d", k), pd16, 1'b0);
        end
        en = 1'b1;
        tick();
        fc = 1'b0;
        chk("unfreeze_f000", led16, 16'hF000);

        // DOT bounce
        areset();
        mode = 2'd1;
        tick();
        chk("dot_start", led16, 16'h8000);
        chk("dot_start_pd", pd16, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            fc = 1'b1;
            tick();
            chk($sformatf("dot_led_%0d", k), led16, dot16(k));
            chk($sformatf("dot_pd_%0d", k), pd16, (k == 30) ? 1'b1 : 1'b0);
        end
        fc = 1'b0;

        // Mode change coincident with fc: reload only, then BLINK
        areset();
        tick();
        for (int k = 1; k <= 7; k++) begin
            fc = 1'b1;
            tick();
        end
        chk("dot_0100", led16, 16'h0100);
        mode = 2'd2;
        tick();
        chk("blink_reload", led16, 16'h0000);
        chk("blink_reload_pd", pd16, 1'b0);
        tick();
        chk("blink_ffff", led16, 16'hFFFF);
        chk("blink_ffff_pd", pd16, 1'b0);
        tick();
        chk("blink_0000", led16, 16'h0000);
        chk("blink_0000_pd", pd16, 1'b1);
        fc = 1'b0;

        // FILL on the 4-LED instance
        mode = 2'd0;
        areset();
        chk("w4_rst_dot", led4, 4'h8);
        tick();
        chk("w4_reload_fill", led4, 4'h0);
        for (int k = 0; k < 8; k++) begin
            fc = 1'b1;
            tick();
            chk($sformatf("w4_led_%0d", k + 1), led4, seq4[k]);
            chk($sformatf("w4_pd_%0d", k + 1), pd4, (k == 7) ? 1'b1 : 1'b0);
        end
        fc = 1'b0;

        // COUNT full period
        areset();
        mode = 2'd3;
        tick();
        chk("count_start", led16, 16'h0000);
        bad   = 0;
        npd   = 0;
        badpd = 0;
        fc    = 1'b1;
        for (int k = 1; k <= 65536; k++) begin
            tick();
            if (led16 !== k[15:0]) bad++;
            if (pd16 === 1'b1) begin
                npd++;
                if (led16 !== 16'h0000) badpd++;
            end
        end
        fc = 1'b0;
        chk("count_led_errors", bad, 0);
        chk("count_pd_pulses", npd, 1);
        chk("count_pd_misaligned", badpd, 0);
        chk("count_wrap_led", led16, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
